box_cmd_sequencer: RTL and testbench

Upstream command stage for the 4x4 box drawer. It accepts box-draw and screen-clear commands over a valid/ready interface and buffers them in a small FIFO. It replays each command to the drawer as that block's pulse protocol: X on the shared coordinate bus with a load pulse, then Y and colour with a plot pulse, or a single black pulse for a clear. It waits for the drawer's done handshake before issuing the next command, and flags a sticky error if the drawer stalls.

---
 rtl/box_draw_pkg.sv | 33 +++
 rtl/box_cmd_sequencer_if.sv | 15 +
 rtl/box_cmd_fifo.sv | 53 +++++
 rtl/box_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_box_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_draw_pkg.sv
// rtl/box_draw_pkg.sv - shared types and constants for the box drawer command path
package box_draw_pkg;

  localparam int X_W      = 7;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int CMD_W    = 1 + X_W + Y_W + COLOUR_W;
  localparam int CNT_W    = 15;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SETUP_X   = 4'd1,
    ST_PULSE_X   = 4'd2,
    ST_GAP       = 4'd3,
    ST_SETUP_Y   = 4'd4,
    ST_PULSE_P   = 4'd5,
    ST_SETUP_B   = 4'd6,
    ST_PULSE_B   = 4'd7,
    ST_WAIT_LOW  = 4'd8,
    ST_WAIT_DONE = 4'd9
  } seq_state_t;

  typedef struct packed {
    logic                clear;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } box_cmd_t;

endpackage

// File: rtl/box_cmd_sequencer_if.sv
// rtl/box_cmd_sequencer_if.sv - command valid/ready channel into the sequencer
interface box_cmd_sequencer_if;
  import box_draw_pkg::*;

  logic                iCmdValid;
  logic                oCmdReady;
  logic                iCmdClear;
  logic [X_W-1:0]      iCmdX;
  logic [Y_W-1:0]      iCmdY;
  logic [COLOUR_W-1:0] iCmdColour;

  modport master (output iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour, input oCmdReady);
  modport slave  (input iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour, output oCmdReady);

endinterface

// File: rtl/box_cmd_fifo.sv
// rtl/box_cmd_fifo.sv - synchronous command FIFO with separately tracked level
module box_cmd_fifo
  import box_draw_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     iClock,
  input  logic     iResetn,
  input  logic     push,
  input  logic     pop,
  input  box_cmd_t push_data,
  output box_cmd_t head,
  output logic [AW:0] level,
  output logic     full,
  output logic     empty
);

  box_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: level gates every read, so stale entries are never seen.
  always_ff @(posedge iClock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level disambiguates full/empty.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/box_cmd_sequencer.sv
// rtl/box_cmd_sequencer.sv - replays queued box/clear commands as drawer pulse sequences
module box_cmd_sequencer
  import box_draw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1,
  parameter int PULSE_LEN  = 2,
  parameter int TIMEOUT    = 20000
) (
  input  logic                        iClock,
  input  logic                        iResetn,
  box_cmd_sequencer_if.slave          cmd,
  output logic                        oLoadX,
  output logic                        oPlotBox,
  output logic                        oBlack,
  output logic [X_W-1:0]              oXY_Coord,
  output logic [COLOUR_W-1:0]         oColour,
  input  logic                        iDone,
  output logic                        oBusy,
  output logic [$clog2(FIFO_DEPTH):0] oLevel,
  output logic                        oError
);

  seq_state_t          state, state_n;
  box_cmd_t            in_cmd, fifo_head;
  logic                fifo_full, fifo_empty, pop;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [CNT_W-1:0]    cnt;
  logic                waiting, timeout_hit;
  logic                load_n, plot_n, black_n, busy_n, error_n;
  logic [X_W-1:0]      coord_n;
  logic [COLOUR_W-1:0] colour_n;

  assign in_cmd        = '{clear: cmd.iCmdClear, x: cmd.iCmdX, y: cmd.iCmdY, colour: cmd.iCmdColour};
  assign cmd.oCmdReady = !fifo_full;
  assign pop           = (state == ST_IDLE) && !fifo_empty;

  box_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .iClock    (iClock),
    .iResetn   (iResetn),
    .push      (cmd.iCmdValid),
    .pop       (pop),
    .push_data (in_cmd),
    .head      (fifo_head),
    .level     (oLevel),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A completing done in the same cycle as the deadline wins over the timeout.
  assign waiting     = (state == ST_WAIT_LOW) || (state == ST_WAIT_DONE);
  assign timeout_hit = waiting && (cnt == CNT_W'(TIMEOUT)) && !((state == ST_WAIT_DONE) && iDone);

  // State register.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state: fixed pulse script per command, then the two-phase done handshake.
  always_comb begin
    state_n = state;
    if (timeout_hit) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (!fifo_empty) state_n = fifo_head.clear ? ST_SETUP_B : ST_SETUP_X;
        ST_SETUP_X:   if (cnt == CNT_W'(SETTLE - 1))    state_n = ST_PULSE_X;
        ST_PULSE_X:   if (cnt == CNT_W'(PULSE_LEN - 1)) state_n = ST_GAP;
        ST_GAP:       state_n = ST_SETUP_Y;
        ST_SETUP_Y:   if (cnt == CNT_W'(SETTLE - 1))    state_n = ST_PULSE_P;
        ST_PULSE_P:   if (cnt == CNT_W'(PULSE_LEN - 1)) state_n = ST_WAIT_LOW;
        ST_SETUP_B:   if (cnt == CNT_W'(SETTLE - 1))    state_n = ST_PULSE_B;
        ST_PULSE_B:   if (cnt == CNT_W'(PULSE_LEN - 1)) state_n = ST_WAIT_LOW;
        ST_WAIT_LOW:  if (!iDone) state_n = ST_WAIT_DONE;
        ST_WAIT_DONE: if (iDone)  state_n = ST_IDLE;
        default:      state_n = ST_IDLE;
      endcase
    end
  end

  // Phase counter restarts on every state change, but keeps running from WAIT_LOW into WAIT_DONE.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn)                                                    cnt <= '0;
    else if (state == ST_IDLE || (state_n != state && state_n != ST_WAIT_DONE)) cnt <= '0;
    else                                                             cnt <= cnt + 1'b1;
  end

  // Capture the head on pop so the FIFO slot frees while the command plays out.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else if (pop) begin
      x_q      <= fifo_head.x;
      y_q      <= fifo_head.y;
      colour_q <= fifo_head.colour;
    end
  end

  // Output decode: coordinate and colour hold their last value outside the setup/pulse phases.
  always_comb begin
    load_n   = 1'b0;
    plot_n   = 1'b0;
    black_n  = 1'b0;
    coord_n  = oXY_Coord;
    colour_n = oColour;
    busy_n   = (state != ST_IDLE);
    error_n  = oError | timeout_hit;
    case (state)
      ST_SETUP_X, ST_GAP: coord_n = x_q;
      ST_PULSE_X: begin
        coord_n = x_q;
        load_n  = 1'b1;
      end
      ST_SETUP_Y: begin
        coord_n  = y_q;
        colour_n = colour_q;
      end
      ST_PULSE_P: begin
        coord_n  = y_q;
        colour_n = colour_q;
        plot_n   = 1'b1;
      end
      ST_PULSE_B: black_n = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset drops any pulse in flight immediately.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oLoadX    <= 1'b0;
      oPlotBox  <= 1'b0;
      oBlack    <= 1'b0;
      oXY_Coord <= '0;
      oColour   <= '0;
      oBusy     <= 1'b0;
      oError    <= 1'b0;
    end else begin
      oLoadX    <= load_n;
      oPlotBox  <= plot_n;
      oBlack    <= black_n;
      oXY_Coord <= coord_n;
      oColour   <= colour_n;
      oBusy     <= busy_n;
      oError    <= error_n;
    end
  end

endmodule

// File: tb/tb_box_cmd_sequencer.sv
// tb/tb_box_cmd_sequencer.sv - scoreboard bench for box_cmd_sequencer
module tb_box_cmd_sequencer;
  import box_draw_pkg::*;

  localparam int FIFO_DEPTH   = 4;
  localparam int SETTLE       = 1;
  localparam int PULSE_LEN    = 2;
  localparam int TIMEOUT      = 20000;
  localparam int CLEAR_PIXELS = 160 * 120;

  logic       iClock  = 1'b0;
  logic       iResetn = 1'b0;
  logic       oLoadX, oPlotBox, oBlack, oBusy, oError;
  logic [6:0] oXY_Coord;
  logic [2:0] oColour;
  logic [2:0] oLevel;
  logic       iDone;

  box_cmd_sequencer_if cmd_if();

  box_cmd_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClock    (iClock),
    .iResetn   (iResetn),
    .cmd       (cmd_if),
    .oLoadX    (oLoadX),
    .oPlotBox  (oPlotBox),
    .oBlack    (oBlack),
    .oXY_Coord (oXY_Coord),
    .oColour   (oColour),
    .iDone     (iDone),
    .oBusy     (oBusy),
    .oLevel    (oLevel),
    .oError    (oError)
  );

  always #5 iClock = ~iClock;

  int          checks = 0;
  int          errors = 0;
  int          scored = 0;
  logic [17:0] exp_q[$];
  bit          auto_drawer = 1'b0;
  bit          man_done    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input logic [17:0] got, input bit is_clear);
    logic [17:0] e;
    check("sb_has_entry", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (is_clear) check("cmd_is_clear", 32'(e[17]), 1);
      else          check("cmd_box_fields", 32'(got), 32'(e));
      scored++;
    end
  endtask

  // Monitor: reconstructs each command from the drawer pins and scores it against the queue.
  int         ld_len = 0, pl_len = 0, bk_len = 0;
  logic [6:0] x_seen, y_seen;
  logic [2:0] c_seen;
  always @(negedge iClock) begin
    if (!iResetn) begin
      ld_len = 0; pl_len = 0; bk_len = 0;
    end else begin
      if (oLoadX || oPlotBox || oBlack)
        check("pulse_exclusive", 32'(int'(oLoadX) + int'(oPlotBox) + int'(oBlack)), 1);
      if (oLoadX) begin
        if (ld_len > 0) check("x_hold", 32'(oXY_Coord), 32'(x_seen));
        x_seen = oXY_Coord;
        ld_len++;
      end else if (ld_len > 0) begin
        check("loadx_len", 32'(ld_len), PULSE_LEN);
        check("gap_coord", 32'(oXY_Coord), 32'(x_seen));
        ld_len = 0;
      end
      if (oPlotBox) begin
        if (pl_len > 0) begin
          check("y_hold", 32'(oXY_Coord), 32'(y_seen));
          check("colour_hold", 32'(oColour), 32'(c_seen));
        end
        y_seen = oXY_Coord;
        c_seen = oColour;
        pl_len++;
      end else if (pl_len > 0) begin
        check("plot_len", 32'(pl_len), PULSE_LEN);
        score({1'b0, x_seen, y_seen, c_seen}, 1'b0);
        pl_len = 0;
      end
      if (oBlack) bk_len++;
      else if (bk_len > 0) begin
        check("black_len", 32'(bk_len), PULSE_LEN);
        score('0, 1'b1);
        bk_len = 0;
      end
    end
  end

  // Drawer model: done drops a few cycles after a pulse ends and rises after the draw time.
  initial begin
    iDone = 1'b1;
    forever begin
      @(negedge iClock);
      if (!auto_drawer) begin
        iDone = man_done;
      end else if (iResetn && (oPlotBox || oBlack)) begin
        int n;
        n = oBlack ? CLEAR_PIXELS : 16 + int'($urandom_range(0, 8));
        while (oPlotBox || oBlack) @(negedge iClock);
        repeat ($urandom_range(0, 3)) @(negedge iClock);
        iDone = 1'b0;
        repeat (n) @(negedge iClock);
        iDone = 1'b1;
      end
    end
  end

  // Call at a negedge; returns at the negedge after acceptance.
  task automatic push_cmd(input logic clr, input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
    int w = 0;
    cmd_if.iCmdValid  = 1'b1;
    cmd_if.iCmdClear  = clr;
    cmd_if.iCmdX      = x;
    cmd_if.iCmdY      = y;
    cmd_if.iCmdColour = c;
    while (!cmd_if.oCmdReady && w < 5000) begin
      @(negedge iClock);
      w++;
    end
    check("push_accepted", 32'(w < 5000), 1);
    exp_q.push_back({clr, x, y, c});
    @(negedge iClock);
    cmd_if.iCmdValid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int w = 0;
    while ((exp_q.size() != 0 || oBusy || oLevel != 0) && w < bound) begin
      @(negedge iClock);
      w++;
    end
    check("drain_in_time", 32'(w < bound), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    int base;
    cmd_if.iCmdValid = 1'b0; cmd_if.iCmdClear = 1'b0;
    cmd_if.iCmdX = '0; cmd_if.iCmdY = '0; cmd_if.iCmdColour = '0;

    // Reset state
    repeat (3) @(negedge iClock);
    check("rst_level", 32'(oLevel), 0);
    check("rst_ready", 32'(cmd_if.oCmdReady), 1);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_error", 32'(oError), 0);
    check("rst_pulses", 32'({oLoadX, oPlotBox, oBlack}), 0);
    check("rst_coord", 32'({oXY_Coord, oColour}), 0);
    iResetn = 1'b1;
    @(negedge iClock);

    // Reset during PULSE_P
    push_cmd(1'b0, 7'd33, 7'd44, 3'd5);
    w = 0;
    while (!oPlotBox && w < 50) begin @(negedge iClock); w++; end
    check("plot_reached", 32'(oPlotBox), 1);
    iResetn = 1'b0;
    #1;
    check("plot_async_drop", 32'(oPlotBox), 0);
    exp_q.delete();
    repeat (2) @(negedge iClock);
    iResetn = 1'b1;
    @(negedge iClock);
    check("post_rst_level", 32'(oLevel), 0);
    check("post_rst_busy", 32'(oBusy), 0);
    check("post_rst_ready", 32'(cmd_if.oCmdReady), 1);

    // Single box latency with drawer model
    auto_drawer = 1'b1;
    push_cmd(1'b0, 7'd10, 7'd20, 3'b010);
    for (int e = 1; e <= 9; e++) begin
      @(negedge iClock);
      check($sformatf("lat_loadx_e%0d", e), 32'(oLoadX), 32'(e == 3 || e == 4));
      check($sformatf("lat_plot_e%0d", e), 32'(oPlotBox), 32'(e == 7 || e == 8));
      if (e >= 2 && e <= 5) check($sformatf("lat_x_e%0d", e), 32'(oXY_Coord), 10);
      if (e >= 6) begin
        check($sformatf("lat_y_e%0d", e), 32'(oXY_Coord), 20);
        check($sformatf("lat_col_e%0d", e), 32'(oColour), 2);
      end
    end
    w = 0;
    while (iDone && w < 200) begin @(posedge iClock); w++; end
    while (!iDone && w < 200) begin @(posedge iClock); w++; end
    check("drawer_cycle_seen", 32'(w < 200), 1);
    @(negedge iClock);
    check("busy_at_done", 32'(oBusy), 1);
    @(negedge iClock);
    check("busy_after_done", 32'(oBusy), 0);

    // Five back-to-back pushes with the FSM stalled on done
    auto_drawer = 1'b0;
    man_done    = 1'b1;
    base        = scored;
    push_cmd(1'b0, 7'd1, 7'd2, 3'd1);
    check("lvl_first_push", 32'(oLevel), 1);
    push_cmd(1'b0, 7'd3, 7'd4, 3'd2);
    check("lvl_push_and_pop", 32'(oLevel), 1);
    push_cmd(1'b0, 7'd5, 7'd6, 3'd3);
    push_cmd(1'b0, 7'd7, 7'd8, 3'd4);
    push_cmd(1'b0, 7'd9, 7'd10, 3'd5);
    check("lvl_full", 32'(oLevel), 4);
    check("ready_full", 32'(cmd_if.oCmdReady), 0);
    w = 0;
    while (scored == base && w < 100) begin @(negedge iClock); w++; end
    check("first_cmd_played", 32'(scored - base), 1);
    repeat (10) @(negedge iClock);
    check("wait_low_blocks", 32'(oBusy), 1);
    check("wait_low_level", 32'(oLevel), 4);
    man_done = 1'b0;
    repeat (5) @(negedge iClock);
    check("wait_done_blocks", 32'(oBusy), 1);
    man_done = 1'b1;
    repeat (2) @(negedge iClock);
    auto_drawer = 1'b1;
    wait_drain(2000);

    // Clear command, full-screen draw time
    push_cmd(1'b1, 7'($urandom), 7'($urandom), 3'($urandom));
    wait_drain(25000);
    check("clear_no_error", 32'(oError), 0);

    // Drawer never completes: timeout then the next command proceeds
    auto_drawer = 1'b0;
    man_done    = 1'b0;
    push_cmd(1'b0, 7'd100, 7'd50, 3'd6);
    push_cmd(1'b0, 7'd60, 7'd70, 3'd7);
    w = 0;
    while (!oPlotBox && w < 60) begin @(negedge iClock); w++; end
    while (oPlotBox && w < 60) begin @(negedge iClock); w++; end
    check("timeout_plot_seen", 32'(w < 60), 1);
    k = 0;
    while (!oError && k < TIMEOUT + 10) begin @(negedge iClock); k++; end
    check("timeout_cycles", 32'(k), TIMEOUT);
    man_done = 1'b1;
    repeat (2) @(negedge iClock);
    auto_drawer = 1'b1;
    wait_drain(500);
    check("error_sticky", 32'(oError), 1);

    // Randomized boxes against the scoreboard
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'b0, 7'($urandom), 7'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 25)) @(negedge iClock);
    end
    wait_drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
